// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - operand/result handshake bundle for the sequential ALU
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] alu_src1;
  logic [WIDTH-1:0] alu_src2;
  logic [2:0]       alu_ctr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] alu_result;
  logic             zero_bit;
  logic             carry_bit;
  logic             overflow_bit;

  modport master (
    output in_valid, alu_src1, alu_src2, alu_ctr, out_ready,
    input  in_ready, out_valid, alu_result, zero_bit, carry_bit, overflow_bit
  );

  modport slave (
    input  in_valid, alu_src1, alu_src2, alu_ctr, out_ready,
    output in_ready, out_valid, alu_result, zero_bit, carry_bit, overflow_bit
  );
endinterface

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked ALU with registered flags and iterative unsigned MOD
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic clk,
  input  logic reset,
  alu_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  state_t           r_state, w_state_next;
  logic [WIDTH-1:0] r_result;
  logic             r_carry, r_ovf;
  logic [WIDTH-1:0] r_dvd, r_dvs, r_rem;
  logic [CNT_W-1:0] r_cnt;

  logic             w_accept, w_last, w_is_mod;
  logic [WIDTH:0]   w_sum, w_diff, w_shift, w_trial;
  logic [WIDTH-1:0] w_rem_next, w_alu;
  logic             w_c, w_v, w_slt;

  assign w_accept = bus.in_valid && (r_state == IDLE);
  assign w_is_mod = (bus.alu_ctr == 3'b111);
  assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

  // Restoring step: bring in the next dividend bit, subtract the divisor if it fits.
  assign w_shift    = {r_rem, r_dvd[WIDTH-1]};
  assign w_trial    = w_shift - {1'b0, r_dvs};
  assign w_rem_next = w_trial[WIDTH] ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];

  assign w_sum  = {1'b0, bus.alu_src1} + {1'b0, bus.alu_src2};
  assign w_diff = {1'b0, bus.alu_src1} - {1'b0, bus.alu_src2};
  assign w_slt  = ($signed(bus.alu_src1) < $signed(bus.alu_src2));

  always_comb begin
    w_alu = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (bus.alu_ctr)
      3'b000: w_alu = bus.alu_src1 & bus.alu_src2;
      3'b001: w_alu = bus.alu_src1 | bus.alu_src2;
      3'b010: w_alu = bus.alu_src1 ^ bus.alu_src2;
      3'b011: w_alu = ~(bus.alu_src1 | bus.alu_src2);
      3'b100: w_alu = {{(WIDTH-1){1'b0}}, w_slt};
      3'b101: begin
        w_alu = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (bus.alu_src1[WIDTH-1] == bus.alu_src2[WIDTH-1]) &&
                (w_sum[WIDTH-1] != bus.alu_src1[WIDTH-1]);
      end
      3'b110: begin
        w_alu = w_diff[WIDTH-1:0];
        w_c   = ~w_diff[WIDTH];
        w_v   = (bus.alu_src1[WIDTH-1] != bus.alu_src2[WIDTH-1]) &&
                (w_diff[WIDTH-1] != bus.alu_src1[WIDTH-1]);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_next = w_is_mod ? DIV : DONE;
      DIV:     if (w_last) w_state_next = DONE;
      DONE:    if (bus.out_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_result <= '0;
      r_carry  <= 1'b0;
      r_ovf    <= 1'b0;
      r_dvd    <= '0;
      r_dvs    <= '0;
      r_rem    <= '0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_dvd <= bus.alu_src1;
      r_dvs <= bus.alu_src2;
      r_rem <= '0;
      r_cnt <= '0;
      if (!w_is_mod) begin
        r_result <= w_alu;
        r_carry  <= w_c;
        r_ovf    <= w_v;
      end
    end else if (r_state == DIV) begin
      r_rem <= w_rem_next;
      r_dvd <= {r_dvd[WIDTH-2:0], 1'b0};
      r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        r_result <= w_rem_next;
        r_carry  <= 1'b0;
        r_ovf    <= 1'b0;
      end
    end
  end

  assign bus.in_ready     = (r_state == IDLE);
  assign bus.out_valid    = (r_state == DONE);
  assign bus.alu_result   = r_result;
  assign bus.zero_bit     = (r_result == '0);
  assign bus.carry_bit    = r_carry;
  assign bus.overflow_bit = r_ovf;
endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - vector table and scoreboard bench for 32-bit and 8-bit alu_seq
module tb_alu_seq;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        t_sel;
  logic        t_in_valid, t_out_ready;
  logic [31:0] t_src1, t_src2;
  logic [2:0]  t_ctr;

  alu_seq_if #(.WIDTH(32)) bus32 ();
  alu_seq_if #(.WIDTH(8))  bus8 ();

  alu_seq #(.WIDTH(32), .CNT_W(6)) u_dut32 (.clk(clk), .reset(reset), .bus(bus32));
  alu_seq #(.WIDTH(8),  .CNT_W(4)) u_dut8  (.clk(clk), .reset(reset), .bus(bus8));

  assign bus32.in_valid  = t_in_valid && !t_sel;
  assign bus32.alu_src1  = t_src1;
  assign bus32.alu_src2  = t_src2;
  assign bus32.alu_ctr   = t_ctr;
  assign bus32.out_ready = t_out_ready;
  assign bus8.in_valid   = t_in_valid && t_sel;
  assign bus8.alu_src1   = t_src1[7:0];
  assign bus8.alu_src2   = t_src2[7:0];
  assign bus8.alu_ctr    = t_ctr;
  assign bus8.out_ready  = t_out_ready;

  logic        m_in_ready, m_out_valid, m_zero, m_carry, m_ovf;
  logic [31:0] m_result;
  assign m_in_ready  = t_sel ? bus8.in_ready  : bus32.in_ready;
  assign m_out_valid = t_sel ? bus8.out_valid : bus32.out_valid;
  assign m_result    = t_sel ? {24'h0, bus8.alu_result} : bus32.alu_result;
  assign m_zero      = t_sel ? bus8.zero_bit     : bus32.zero_bit;
  assign m_carry     = t_sel ? bus8.carry_bit    : bus32.carry_bit;
  assign m_ovf       = t_sel ? bus8.overflow_bit : bus32.overflow_bit;

  typedef struct {
    logic        sel;
    logic [2:0]  ctr;
    logic [31:0] a, b, res;
    logic        z, c, v;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        z, c, v;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic vec_t mk(input logic sel, input logic [2:0] ctr, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] res, input logic z,
                              input logic c, input logic v, input int lat);
    vec_t t;
    t.sel = sel; t.ctr = ctr; t.a = a; t.b = b; t.res = res;
    t.z = z; t.c = c; t.v = v; t.lat = lat;
    return t;
  endfunction

  task automatic push_exp(input logic [31:0] res, input logic z, input logic c, input logic v);
    exp_t e;
    e.res = res; e.z = z; e.c = c; e.v = v;
    sb.push_back(e);
  endtask

  task automatic pop_compare(input string tag);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL %s scoreboard empty actual=%h required=<none>", tag, m_result);
    end else begin
      e = sb.pop_front();
      check({tag, " result"}, m_result, e.res);
      check({tag, " zero"}, {31'h0, m_zero}, {31'h0, e.z});
      check({tag, " carry"}, {31'h0, m_carry}, {31'h0, e.c});
      check({tag, " overflow"}, {31'h0, m_ovf}, {31'h0, e.v});
    end
  endtask

  // Leaves the caller #1 after the edge on which out_valid was first seen.
  task automatic wait_valid(input string tag, input int lat_req);
    int lat = 1;
    while (!m_out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(lat_req));
  endtask

  task automatic run_vec(input vec_t t, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    @(negedge clk);
    t_sel = t.sel; t_ctr = t.ctr; t_src1 = t.a; t_src2 = t.b; t_in_valid = 1'b1;
    check({tag, " in_ready"}, {31'h0, m_in_ready}, 32'h1);
    @(posedge clk);
    push_exp(t.res, t.z, t.c, t.v);
    #1;
    t_in_valid = 1'b0;
    t_src1 = $urandom; t_src2 = $urandom; t_ctr = 3'($urandom);
    wait_valid(tag, t.lat);
    pop_compare(tag);
    @(posedge clk); #1;
    check({tag, " released"}, {31'h0, m_out_valid}, 32'h0);
  endtask

  initial begin
    vecs.push_back(mk(0, 3'b101, 32'hFFFFFFFF, 32'h1,        32'h0,        1, 1, 0, 1));
    vecs.push_back(mk(0, 3'b110, 32'h80000000, 32'h1,        32'h7FFFFFFF, 0, 1, 1, 1));
    vecs.push_back(mk(0, 3'b100, 32'hFFFFFFFF, 32'h1,        32'h1,        0, 0, 0, 1));
    vecs.push_back(mk(0, 3'b100, 32'h1,        32'hFFFFFFFF, 32'h0,        1, 0, 0, 1));
    vecs.push_back(mk(0, 3'b011, 32'h0,        32'h0,        32'hFFFFFFFF, 0, 0, 0, 1));
    vecs.push_back(mk(0, 3'b000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 0, 0, 0, 1));
    vecs.push_back(mk(0, 3'b001, 32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 3'b010, 32'h12345678, 32'h12345678, 32'h0,        1, 0, 0, 1));
    vecs.push_back(mk(0, 3'b110, 32'h1,        32'h2,        32'hFFFFFFFF, 0, 0, 0, 1));
    vecs.push_back(mk(0, 3'b110, 32'h5,        32'h5,        32'h0,        1, 1, 0, 1));
    vecs.push_back(mk(0, 3'b101, 32'h7FFFFFFF, 32'h1,        32'h80000000, 0, 0, 1, 1));
    vecs.push_back(mk(0, 3'b101, 32'h80000000, 32'h80000000, 32'h0,        1, 1, 1, 1));
    vecs.push_back(mk(0, 3'b111, 32'd100,      32'd7,        32'd2,        0, 0, 0, 33));
    vecs.push_back(mk(0, 3'b111, 32'hFFFFFFFF, 32'h10,       32'hF,        0, 0, 0, 33));
    vecs.push_back(mk(0, 3'b111, 32'd5,        32'd9,        32'd5,        0, 0, 0, 33));
    vecs.push_back(mk(0, 3'b111, 32'd6,        32'd3,        32'd0,        1, 0, 0, 33));
    vecs.push_back(mk(0, 3'b111, 32'd1234,     32'd0,        32'd1234,     0, 0, 0, 33));
    vecs.push_back(mk(0, 3'b111, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        1, 0, 0, 33));
    vecs.push_back(mk(1, 3'b101, 32'h7F,       32'h1,        32'h80,       0, 0, 1, 1));
    vecs.push_back(mk(1, 3'b110, 32'h0,        32'h1,        32'hFF,       0, 0, 0, 1));
    vecs.push_back(mk(1, 3'b111, 32'd200,      32'd13,       32'd5,        0, 0, 0, 9));
    vecs.push_back(mk(1, 3'b111, 32'd255,      32'd0,        32'd255,      0, 0, 0, 9));

    t_sel = 1'b0; t_in_valid = 1'b0; t_out_ready = 1'b1;
    t_src1 = '0; t_src2 = '0; t_ctr = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst in_ready", {31'h0, m_in_ready}, 32'h1);
    check("rst out_valid", {31'h0, m_out_valid}, 32'h0);
    check("rst result", m_result, 32'h0);
    check("rst zero", {31'h0, m_zero}, 32'h1);
    check("rst carry", {31'h0, m_carry}, 32'h0);
    check("rst overflow", {31'h0, m_ovf}, 32'h0);
    check("rst8 result", {24'h0, bus8.alu_result}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Reset ten cycles into a MOD: the operation is abandoned.
    @(negedge clk);
    t_sel = 1'b0; t_ctr = 3'b111; t_src1 = 32'd100; t_src2 = 32'd7; t_in_valid = 1'b1;
    @(posedge clk);
    push_exp(32'd2, 1'b0, 1'b0, 1'b0);
    #1;
    t_in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    sb.delete();
    check("midmod in_ready", {31'h0, m_in_ready}, 32'h1);
    check("midmod out_valid", {31'h0, m_out_valid}, 32'h0);
    check("midmod result", m_result, 32'h0);
    check("midmod zero", {31'h0, m_zero}, 32'h1);
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("midmod no stray result", {31'h0, m_out_valid}, 32'h0);
    run_vec(mk(0, 3'b101, 32'h1, 32'h1, 32'h2, 0, 0, 0, 1), 100);

    // Back-pressure: result held while a second request waits.
    t_out_ready = 1'b0;
    @(negedge clk);
    t_sel = 1'b0; t_ctr = 3'b010; t_src1 = 32'hF0F0F0F0; t_src2 = 32'hFF00FF00; t_in_valid = 1'b1;
    @(posedge clk);
    push_exp(32'h0FF00FF0, 1'b0, 1'b0, 1'b0);
    #1;
    t_in_valid = 1'b0;
    wait_valid("bp xor", 1);
    pop_compare("bp xor");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      t_ctr = 3'b101; t_src1 = 32'd3; t_src2 = 32'd4; t_in_valid = 1'b1;
      check($sformatf("bp hold%0d result", i), m_result, 32'h0FF00FF0);
      check($sformatf("bp hold%0d in_ready", i), {31'h0, m_in_ready}, 32'h0);
      check($sformatf("bp hold%0d out_valid", i), {31'h0, m_out_valid}, 32'h1);
    end
    @(negedge clk);
    t_out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp release out_valid", {31'h0, m_out_valid}, 32'h0);
    check("bp release in_ready", {31'h0, m_in_ready}, 32'h1);
    @(posedge clk);
    push_exp(32'd7, 1'b0, 1'b0, 1'b0);
    #1;
    t_in_valid = 1'b0;
    wait_valid("bp add", 1);
    pop_compare("bp add");
    @(posedge clk); #1;
    check("bp end out_valid", {31'h0, m_out_valid}, 32'h0);
    check("scoreboard drained", 32'(sb.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
